// File: rtl/bus_cycle_ctrl.sv
// Bus cycle sequencer: runs one address/data handshake per CPU request and
// reports completion (done) or a missing slave reply (buserr).
module bus_cycle_ctrl #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic [15:0] dba,
  input  logic [15:0] dbo,
  output logic [15:0] dbi,
  output logic        busy,
  output logic        done,
  output logic        buserr,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_dout,
  input  logic [15:0] bus_din,
  output logic        bus_sync,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        bus_wtbt,
  input  logic        bus_rply
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, XFER, RELEASE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          is_rd, is_rd_nx;
  logic          is_byte, is_byte_nx;
  logic [15:0]   dbi_nx, addr_nx, dout_nx;
  logic          done_nx, buserr_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_rd    <= 1'b0;
      is_byte  <= 1'b0;
      dbi      <= '0;
      bus_addr <= '0;
      bus_dout <= '0;
      done     <= 1'b0;
      buserr   <= 1'b0;
    end else if (ce) begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      is_rd    <= is_rd_nx;
      is_byte  <= is_byte_nx;
      dbi      <= dbi_nx;
      bus_addr <= addr_nx;
      bus_dout <= dout_nx;
      done     <= done_nx;
      buserr   <= buserr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    is_rd_nx   = is_rd;
    is_byte_nx = is_byte;
    dbi_nx     = dbi;
    addr_nx    = bus_addr;
    dout_nx    = bus_dout;
    done_nx    = 1'b0;
    buserr_nx  = 1'b0;
    case (state)
      IDLE: begin
        // A reply still asserted from a previous slave blocks the new cycle.
        if ((req_rd || req_wr) && !bus_rply) begin
          addr_nx    = dba;
          is_rd_nx   = req_rd;
          is_byte_nx = req_byte;
          dout_nx    = (req_byte && dba[0]) ? {dbo[7:0], dbo[7:0]} : dbo;
          cnt_nx     = '0;
          state_nx   = ADDR;
        end
      end
      ADDR: state_nx = XFER;
      XFER: begin
        // Reply takes priority over the timeout when both land together.
        if (bus_rply) begin
          if (is_rd)
            dbi_nx = (is_byte && bus_addr[0]) ? {bus_din[15:8], bus_din[15:8]} : bus_din;
          state_nx = RELEASE;
        end else if (cnt == CW'(TIMEOUT)) begin
          buserr_nx = 1'b1;
          state_nx  = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!bus_rply) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset clears them without a clock.
  assign busy     = (state != IDLE);
  assign bus_sync = (state == ADDR) || (state == XFER);
  assign bus_rd   = (state == XFER) && is_rd;
  assign bus_wr   = (state == XFER) && !is_rd;
  assign bus_wtbt = (state == XFER) && !is_rd;

endmodule
